// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types, widths and helpers for the instruction fetch controller.
package imem_fetch_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  // A fetchable PC is word aligned and no higher than the last memory word.
  function automatic logic pc_is_legal(input logic [31:0] pc, input logic [31:0] last_pc);
    return (pc[1:0] == 2'b00) && (pc <= last_pc);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Fetch buffer: small circular store feeding a registered head stage,
// with synchronous flush for redirects.
module fetch_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             consume;
  logic             advance;
  logic             push_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;

  // The head register reloads whenever it is empty or being consumed.
  assign consume = pop && head_valid_q;
  assign advance = !empty && (!head_valid_q || consume);
  assign push_ok = push && (!full || advance);

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (advance) begin
        head_data_d  = mem_q[rd_ptr_q];
        head_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
      end else if (consume) begin
        head_valid_d = 1'b0;
      end
      case ({push_ok, advance})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads the single-cycle
// instruction memory and buffers {pc, instr} pairs toward decode.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          MEM_DEPTH  = 1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               fault,
  output logic [31:0]        fault_pc
);

  localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH * 4 - 4);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          fault_pc_q, fault_pc_d;
  logic                 fifo_push;
  logic                 fifo_flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head_valid;
  logic [ENTRY_W-1:0]   head_data;
  logic                 room;
  logic                 pc_legal;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_data  ({pc_q, imem_rdata}),
    .pop        (out_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  // A full store still has room when an entry moves into the head this cycle.
  assign room     = !fifo_full || (!fifo_empty && (!head_valid || out_ready));
  assign pc_legal = pc_is_legal(pc_q, LAST_PC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc;
        end else if (en) begin
          state_d = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc;
        end else if (!en) begin
          state_d = FETCH_IDLE;
        end else if (!pc_legal) begin
          state_d    = FETCH_FAULT;
          fault_pc_d = pc_q;
        end else if (room) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + 32'd4;
        end
      end
      FETCH_FAULT: begin
        state_d = FETCH_FAULT;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = head_valid;
  assign out_pc    = head_data[ENTRY_W-1:INSTR_W];
  assign out_instr = head_data[INSTR_W-1:0];
  assign fault     = (state_q == FETCH_FAULT);
  assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_fetch_ctrl;

  localparam int          MEM_DEPTH = 1024;
  localparam int          FIFO_D    = 2;
  localparam logic [31:0] LAST_PC   = 32'd4092;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] tb_mem [MEM_DEPTH];

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          vis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fault_pc;
  bit          m_running;
  bit          m_faulted;

  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .MEM_DEPTH  (MEM_DEPTH),
    .FIFO_DEPTH (FIFO_D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  assign imem_rdata = tb_mem[imem_addr[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge so they are stable well
  // before the model samples them at the falling edge.
  task automatic applyStimulus(input bit e, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    en             = e;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc       = 32'h0;
    m_fault_pc = 32'h0;
    m_running  = 1'b0;
    m_faulted  = 1'b0;
  endtask

  // Reference behaviour: an ordered queue of fetched entries, where an entry
  // becomes visible to decode one edge after it reaches the front of storage.
  task automatic model_step();
    bit          head_vis;
    bit          accept;
    bit          moving;
    bit          room;
    bit          legal;
    bit          do_flush;
    bit          do_push;
    int          stored;
    logic [31:0] push_pc;
    head_vis = (mq.size() > 0) && mq[0].vis;
    stored   = mq.size() - (head_vis ? 1 : 0);
    accept   = head_vis && out_ready;
    moving   = (stored > 0) && (!head_vis || out_ready);
    room     = (stored < FIFO_D) || ((stored == FIFO_D) && moving);
    legal    = (m_pc[1:0] == 2'b00) && (m_pc <= LAST_PC);
    do_flush = 1'b0;
    do_push  = 1'b0;
    push_pc  = m_pc;
    if (!m_faulted) begin
      if (redirect_valid) begin
        do_flush = 1'b1;
        m_pc     = redirect_pc;
      end else if (m_running) begin
        if (!en) begin
          m_running = 1'b0;
        end else if (!legal) begin
          m_faulted  = 1'b1;
          m_running  = 1'b0;
          m_fault_pc = m_pc;
        end else if (room) begin
          do_push = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end else if (en) begin
        m_running = 1'b1;
      end
    end
    if (do_flush) begin
      mq.delete();
    end else begin
      if (accept) void'(mq.pop_front());
      if (moving) mq[0].vis = 1'b1;
    end
    if (do_push) begin
      mq.push_back('{pc: push_pc, instr: tb_mem[push_pc[11:2]], vis: 1'b0});
    end
  endtask

  task automatic compare_all();
    bit ev;
    ev = (mq.size() > 0) && mq[0].vis;
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("out_valid", 32'(out_valid), 32'(ev));
    checkOutput("fault", 32'(fault), 32'(m_faulted));
    checkOutput("fault_pc", fault_pc, m_fault_pc);
    if (ev) begin
      checkOutput("out_pc", out_pc, mq[0].pc);
      checkOutput("out_instr", out_instr, mq[0].instr);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      if (rst) model_reset();
      compare_all();
      if (!rst) begin
        if (out_valid && out_ready) begin
          acc_pc.push_back(out_pc);
          acc_instr.push_back(out_instr);
        end
        model_step();
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          edges;
    logic [31:0] stall_head;
    for (int i = 0; i < MEM_DEPTH; i++) tb_mem[i] = 32'h1000_0000 + 32'(i);
    rst            = 1'b1;
    en             = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    runCycles(3);
    #2;
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    checkOutput("rst_fault_pc", fault_pc, 32'h0);
    rst = 1'b0;

    // Straight-line fetch and enable-to-valid latency.
    acc_pc.delete();
    acc_instr.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    edges = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      edges++;
      #1;
      if (out_valid) break;
    end
    checkOutput("first_valid_edges", 32'(edges), 32'd3);
    runCycles(6);
    checkOutput("straight_count_ok", 32'(acc_pc.size() >= 4), 32'd1);

    // Backpressure: head must hold, store fills, PC freezes.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    stall_head = (acc_pc.size() > 0) ? acc_pc[$] + 32'd4 : 32'h0;
    runCycles(2);
    #1;
    checkOutput("bp_head_pc_early", out_pc, stall_head);
    runCycles(3);
    #1;
    checkOutput("bp_head_pc", out_pc, stall_head);
    checkOutput("bp_head_instr", out_instr, 32'h1000_0000 + (stall_head >> 2));
    checkOutput("bp_addr_frozen", imem_addr, stall_head + 32'd12);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    runCycles(6);
    for (int i = 0; i < acc_pc.size(); i++) begin
      checkOutput("seq_pc", acc_pc[i], 32'(4 * i));
      checkOutput("seq_instr", acc_instr[i], 32'h1000_0000 + 32'(i));
    end

    // Redirect while the buffer is full.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    runCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    acc_pc.delete();
    acc_instr.delete();
    checkOutput("redir_flushed", 32'(out_valid), 32'h0);
    checkOutput("redir_addr", imem_addr, 32'h40);
    @(posedge clk);
    #1;
    checkOutput("redir_valid_e1", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("redir_valid_e2", 32'(out_valid), 32'h1);
    checkOutput("redir_pc_e2", out_pc, 32'h40);
    checkOutput("redir_instr_e2", out_instr, 32'h1000_0010);
    runCycles(3);
    checkOutput("redir_count_ok", 32'(acc_pc.size() >= 2), 32'd1);
    if (acc_pc.size() >= 2) begin
      checkOutput("redir_first", acc_pc[0], 32'h40);
      checkOutput("redir_second", acc_pc[1], 32'h44);
    end

    // Asynchronous reset between edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_imem_addr", imem_addr, 32'h0);
    checkOutput("async_fault", 32'(fault), 32'h0);
    en = 1'b0;
    runCycles(2);
    #2;
    rst = 1'b0;

    // End of memory: one output at 0xFFC then fault at 0x1000.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    runCycles(4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    acc_pc.delete();
    acc_instr.delete();
    @(posedge clk);
    #1;
    checkOutput("eom_fault_e1", 32'(fault), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("eom_valid", 32'(out_valid), 32'h1);
    checkOutput("eom_pc", out_pc, 32'hFFC);
    checkOutput("eom_instr", out_instr, 32'h1000_03FF);
    checkOutput("eom_fault", 32'(fault), 32'h1);
    checkOutput("eom_fault_pc", fault_pc, 32'h1000);
    runCycles(3);
    #1;
    checkOutput("eom_drained", 32'(out_valid), 32'h0);
    checkOutput("eom_outputs", 32'(acc_pc.size()), 32'd1);

    @(posedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    runCycles(2);
    #2;
    rst = 1'b0;

    // Misaligned redirect target, then redirect ignored while faulted.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    runCycles(4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h42);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mis_fault", 32'(fault), 32'h1);
    checkOutput("mis_fault_pc", fault_pc, 32'h42);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    runCycles(3);
    #1;
    checkOutput("mis_no_valid", 32'(out_valid), 32'h0);
    checkOutput("mis_addr_held", imem_addr, 32'h42);
    checkOutput("mis_fault_sticky", 32'(fault), 32'h1);
    checkOutput("mis_fault_pc_held", fault_pc, 32'h42);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
